// File: rtl/mole_game_fsm.sv
// Whack-a-mole game controller: pops moles at random holes, scores key hits,
// counts misses and ends the game after MAX_MISSES misses.
module mole_game_fsm #(
  parameter int unsigned DOWN_CYCLES = 25000000,
  parameter int unsigned UP_CYCLES   = 30000000,
  parameter int unsigned HIT_CYCLES  = 12500000,
  parameter int unsigned MAX_MISSES  = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       play,
  input  logic [3:0] rand_num,
  input  logic [3:0] hit_key,
  output logic       mole_up,
  output logic [1:0] mole_hole,
  output logic [7:0] score,
  output logic [2:0] misses,
  output logic       game_over,
  output logic       hit_pulse
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DOWN     = 3'd1,
    S_UP       = 3'd2,
    S_HIT      = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  localparam logic [24:0] DOWN_LAST  = 25'(DOWN_CYCLES - 1);
  localparam logic [24:0] UP_LAST    = 25'(UP_CYCLES - 1);
  localparam logic [24:0] HIT_LAST   = 25'(HIT_CYCLES - 1);
  localparam logic [2:0]  MISS_LIMIT = 3'(MAX_MISSES);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'd255) begin
      r = 8'd255;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [24:0] timer_q, timer_d;
  logic [3:0]  key_prev_q, key_prev_d;
  logic [1:0]  mole_hole_q, mole_hole_d;
  logic [7:0]  score_q, score_d;
  logic [2:0]  misses_q, misses_d;
  logic        mole_up_q, mole_up_d;
  logic        game_over_q, game_over_d;
  logic        hit_pulse_q, hit_pulse_d;

  logic [3:0]  key_edge_s;
  logic        correct_edge_s;
  logic        down_done_s;
  logic        up_done_s;
  logic        hit_done_s;
  logic [2:0]  misses_inc_s;
  logic        unused_rand_s;

  // Only the two low LFSR bits pick a hole.
  assign unused_rand_s  = ^rand_num[3:2];
  assign key_edge_s     = hit_key & ~key_prev_q;
  assign correct_edge_s = key_edge_s[mole_hole_q];
  assign down_done_s    = (timer_q == DOWN_LAST);
  assign up_done_s      = (timer_q == UP_LAST);
  assign hit_done_s     = (timer_q == HIT_LAST);
  assign misses_inc_s   = misses_q + 3'd1;

  // State register and all output/datapath flops, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      timer_q     <= 25'd0;
      key_prev_q  <= 4'd0;
      mole_hole_q <= 2'd0;
      score_q     <= 8'd0;
      misses_q    <= 3'd0;
      mole_up_q   <= 1'b0;
      game_over_q <= 1'b0;
      hit_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      key_prev_q  <= key_prev_d;
      mole_hole_q <= mole_hole_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      mole_up_q   <= mole_up_d;
      game_over_q <= game_over_d;
      hit_pulse_q <= hit_pulse_d;
    end
  end

  // Next-state logic; play=0 overrides every other transition in an active game.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (play) begin
          state_d = S_DOWN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DOWN: begin
        if (!play) begin
          state_d = S_IDLE;
        end else if (down_done_s) begin
          state_d = S_UP;
        end else begin
          state_d = S_DOWN;
        end
      end
      S_UP: begin
        if (!play) begin
          state_d = S_IDLE;
        end else if (correct_edge_s) begin
          state_d = S_HIT;
        end else if (up_done_s) begin
          if (misses_inc_s == MISS_LIMIT) begin
            state_d = S_GAMEOVER;
          end else begin
            state_d = S_DOWN;
          end
        end else begin
          state_d = S_UP;
        end
      end
      S_HIT: begin
        if (!play) begin
          state_d = S_IDLE;
        end else if (hit_done_s) begin
          state_d = S_DOWN;
        end else begin
          state_d = S_HIT;
        end
      end
      S_GAMEOVER: begin
        if (!play) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAMEOVER;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: timer restarts on every state change; score/misses/hole update on transitions.
  always_comb begin
    key_prev_d  = hit_key;
    timer_d     = timer_q + 25'd1;
    score_d     = score_q;
    misses_d    = misses_q;
    mole_hole_d = mole_hole_q;
    if (state_d != state_q) begin
      timer_d = 25'd0;
    end else begin
      timer_d = timer_q + 25'd1;
    end
    if ((state_q == S_IDLE) && (state_d == S_DOWN)) begin
      score_d  = 8'd0;
      misses_d = 3'd0;
    end else if ((state_q == S_UP) && (state_d == S_HIT)) begin
      score_d  = sat_inc8(score_q);
      misses_d = misses_q;
    end else if ((state_q == S_UP) && ((state_d == S_DOWN) || (state_d == S_GAMEOVER))) begin
      score_d  = score_q;
      misses_d = misses_inc_s;
    end else begin
      score_d  = score_q;
      misses_d = misses_q;
    end
    if ((state_q == S_DOWN) && (state_d == S_UP)) begin
      mole_hole_d = rand_num[1:0];
    end else begin
      mole_hole_d = mole_hole_q;
    end
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    mole_up_d   = (state_d == S_UP);
    game_over_d = (state_d == S_GAMEOVER);
    hit_pulse_d = (state_q == S_UP) && (state_d == S_HIT);
  end

  assign mole_up   = mole_up_q;
  assign mole_hole = mole_hole_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign game_over = game_over_q;
  assign hit_pulse = hit_pulse_q;

endmodule
